// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS pipeline.
// Captures the ID operands, specifiers, immediate and control word, folds a
// same-cycle writeback into the captured operands, detects load-use hazards
// (one bubble), and honours branch flush (highest priority) and EX hold.
// Optional build macro ID_EX_PERF_EN adds perf_bubbles / perf_flushes counters.
module id_ex_stage #(
    parameter int CTRL_W       = 8,
    parameter int REGWRITE_BIT = 0,
    parameter int MEMREAD_BIT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_a3,
    input  logic [31:0]       wb_wd,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rd1,
    output logic [31:0]       ex_rd2,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_flushes
`endif
);

    // Control-word bit indices must be distinct and inside the word.
    if (REGWRITE_BIT == MEMREAD_BIT || REGWRITE_BIT >= CTRL_W || MEMREAD_BIT >= CTRL_W) begin : g_bad_cfg
        $error("id_ex_stage: invalid control bit indices");
    end

    logic              lu_s;
    logic              byp1_s;
    logic              byp2_s;
    logic [31:0]       op1_s;
    logic [31:0]       op2_s;
    logic              nxt_valid_s;
    logic [31:0]       nxt_pc_s;
    logic [31:0]       nxt_rd1_s;
    logic [31:0]       nxt_rd2_s;
    logic [31:0]       nxt_imm_s;
    logic [4:0]        nxt_rs_s;
    logic [4:0]        nxt_rt_s;
    logic [4:0]        nxt_rd_s;
    logic [CTRL_W-1:0] nxt_ctrl_s;

    // Load-use hazard and stall request; register 0 never creates a hazard.
    always_comb begin
        lu_s  = ex_valid & ex_ctrl[MEMREAD_BIT] & id_valid & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (ex_rt == id_rt));
        stall = (lu_s | ex_hold) & ~ex_flush;
    end

    // Writeback bypass: regfile returns the pre-write value in the write cycle.
    always_comb begin
        byp1_s = wb_regwrite & (wb_a3 != 5'd0) & (wb_a3 == id_rs);
        byp2_s = wb_regwrite & (wb_a3 != 5'd0) & (wb_a3 == id_rt);
        if (byp1_s) begin
            op1_s = wb_wd;
        end else begin
            op1_s = id_rd1;
        end
        if (byp2_s) begin
            op2_s = wb_wd;
        end else begin
            op2_s = id_rd2;
        end
    end

    // Next EX contents by priority: flush bubble, hold, load-use bubble, load.
    always_comb begin
        nxt_valid_s = ex_valid;
        nxt_pc_s    = ex_pc;
        nxt_rd1_s   = ex_rd1;
        nxt_rd2_s   = ex_rd2;
        nxt_imm_s   = ex_imm;
        nxt_rs_s    = ex_rs;
        nxt_rt_s    = ex_rt;
        nxt_rd_s    = ex_rd;
        nxt_ctrl_s  = ex_ctrl;
        if (ex_flush || (!ex_hold && lu_s)) begin
            nxt_valid_s = 1'b0;
            nxt_pc_s    = 32'd0;
            nxt_rd1_s   = 32'd0;
            nxt_rd2_s   = 32'd0;
            nxt_imm_s   = 32'd0;
            nxt_rs_s    = 5'd0;
            nxt_rt_s    = 5'd0;
            nxt_rd_s    = 5'd0;
            nxt_ctrl_s  = {CTRL_W{1'b0}};
        end else if (ex_hold) begin
            nxt_valid_s = ex_valid;
        end else begin
            nxt_valid_s = id_valid;
            nxt_pc_s    = id_pc;
            nxt_rd1_s   = op1_s;
            nxt_rd2_s   = op2_s;
            nxt_imm_s   = id_imm;
            nxt_rs_s    = id_rs;
            nxt_rt_s    = id_rt;
            nxt_rd_s    = id_rd;
            // An invalid slot never carries live control bits.
            if (id_valid) begin
                nxt_ctrl_s = id_ctrl;
            end else begin
                nxt_ctrl_s = {CTRL_W{1'b0}};
            end
        end
    end

    // ID/EX pipeline register; reset clears EX immediately, without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_pc    <= 32'd0;
            ex_rd1   <= 32'd0;
            ex_rd2   <= 32'd0;
            ex_imm   <= 32'd0;
            ex_rs    <= 5'd0;
            ex_rt    <= 5'd0;
            ex_rd    <= 5'd0;
            ex_ctrl  <= {CTRL_W{1'b0}};
        end else begin
            ex_valid <= nxt_valid_s;
            ex_pc    <= nxt_pc_s;
            ex_rd1   <= nxt_rd1_s;
            ex_rd2   <= nxt_rd2_s;
            ex_imm   <= nxt_imm_s;
            ex_rs    <= nxt_rs_s;
            ex_rt    <= nxt_rt_s;
            ex_rd    <= nxt_rd_s;
            ex_ctrl  <= nxt_ctrl_s;
        end
    end

`ifdef ID_EX_PERF_EN
    // Event counters: load-use bubbles actually loaded, and flush edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bubbles <= 32'd0;
            perf_flushes <= 32'd0;
        end else begin
            if (ex_flush) begin
                perf_flushes <= perf_flushes + 32'd1;
            end else begin
                perf_flushes <= perf_flushes;
            end
            if (!ex_flush && !ex_hold && lu_s) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end else begin
                perf_bubbles <= perf_bubbles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, async reset check, then
// randomized stimulus compared against a behavioural model of EX contents.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic        wb_we;
        logic [4:0]  wb_a3;
        logic [31:0] wb_wd;
        logic        flush;
        logic        hold;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic        stall;
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [7:0]  ctrl;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ex_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic [31:0] id_imm;
    logic [7:0]  id_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        ex_flush;
    logic        ex_hold;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [7:0]  ex_ctrl;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    ex_t  model;
    int   m_bubbles   = 0;
    int   m_flushes   = 0;
    vec_t tbl [18];

    id_ex_stage #(.CTRL_W(8), .REGWRITE_BIT(0), .MEMREAD_BIT(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_a3(wb_a3), .wb_wd(wb_wd),
        .ex_flush(ex_flush), .ex_hold(ex_hold), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_EN
        ,
        .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input int k, input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [7:0] ctrl,
                               input logic hold, input logic flush, input logic we,
                               input logic [4:0] a3, input logic [31:0] wd);
        in_t i;
        i.valid = v;    i.pc = 32'h400 + 32'(k) * 32'd4;
        i.rs = rs;      i.rt = rt;     i.rd = 5'd3;
        i.rd1 = rd1;    i.rd2 = rd2;   i.imm = 32'(k) + 32'd100;
        i.ctrl = ctrl;  i.wb_we = we;  i.wb_a3 = a3;   i.wb_wd = wd;
        i.flush = flush; i.hold = hold;
        return i;
    endfunction

    // Behavioural reference: a load in EX blocks a dependent reader once.
    function automatic bit m_lu(input ex_t c, input in_t i);
        return c.valid && c.ctrl[1] && i.valid && c.rt != 5'd0 &&
               (c.rt == i.rs || c.rt == i.rt);
    endfunction

    function automatic bit m_stall(input ex_t c, input in_t i);
        return (m_lu(c, i) || i.hold) && !i.flush;
    endfunction

    // Value a reader of register r sees this cycle, including the write in flight.
    function automatic logic [31:0] m_read(input in_t i, input logic [4:0] r, input logic [31:0] rf);
        if (i.wb_we && r != 5'd0 && r == i.wb_a3) return i.wb_wd;
        return rf;
    endfunction

    task automatic m_step(input in_t i);
        ex_t n;
        if (i.flush) begin
            m_flushes++;
            n = '0;
        end else if (i.hold) begin
            n = model;
        end else if (m_lu(model, i)) begin
            m_bubbles++;
            n = '0;
        end else begin
            n = '{valid: i.valid, pc: i.pc, rd1: m_read(i, i.rs, i.rd1),
                  rd2: m_read(i, i.rt, i.rd2), imm: i.imm, rs: i.rs, rt: i.rt,
                  rd: i.rd, ctrl: (i.valid ? i.ctrl : 8'h00)};
        end
        model = n;
    endtask

    // One cycle: drive after negedge, check stall, clock, check EX vs model.
    task automatic apply(input in_t i, output logic st_obs);
        id_valid = i.valid; id_pc = i.pc; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_rd1 = i.rd1; id_rd2 = i.rd2; id_imm = i.imm; id_ctrl = i.ctrl;
        wb_regwrite = i.wb_we; wb_a3 = i.wb_a3; wb_wd = i.wb_wd;
        ex_flush = i.flush; ex_hold = i.hold;
        #1;
        st_obs = stall;
        chk("stall", {31'd0, stall}, {31'd0, m_stall(model, i)});
        @(posedge clk);
        m_step(i);
        #1;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, model.valid});
        chk("ex_pc", ex_pc, model.pc);
        chk("ex_rd1", ex_rd1, model.rd1);
        chk("ex_rd2", ex_rd2, model.rd2);
        chk("ex_imm", ex_imm, model.imm);
        chk("ex_rs", {27'd0, ex_rs}, {27'd0, model.rs});
        chk("ex_rt", {27'd0, ex_rt}, {27'd0, model.rt});
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, model.rd});
        chk("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, model.ctrl});
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_ctrl"}, {24'd0, ex_ctrl}, 32'd0);
        chk({tag, "_rd1"}, ex_rd1, 32'd0);
        chk({tag, "_pc"}, ex_pc, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    // Main sequence: reset, directed table, async reset, random run, summary.
    initial begin
        logic st;
        in_t  ri;
        model = '0;
        rst = 1'b0;
        apply_idle();

        // Directed table {inputs, stall, ex_valid, ex_rd1, ex_rd2, ex_ctrl}.
        tbl[0]  = '{mk(0, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h11, 32'h22, 8'h01};
        tbl[1]  = '{mk(1, 1'b1, 5'd1, 5'd5, 32'h100, 32'h200, 8'h03, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h100, 32'h200, 8'h03};
        tbl[2]  = '{mk(2, 1'b1, 5'd5, 5'd6, 32'h33, 32'h44, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b1, 1'b0, 32'h0, 32'h0, 8'h00};
        tbl[3]  = '{mk(2, 1'b1, 5'd5, 5'd6, 32'h33, 32'h44, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h33, 32'h44, 8'h01};
        tbl[4]  = '{mk(4, 1'b1, 5'd1, 5'd0, 32'h55, 32'h66, 8'h03, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h55, 32'h66, 8'h03};
        tbl[5]  = '{mk(5, 1'b1, 5'd0, 5'd0, 32'h77, 32'h88, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h77, 32'h88, 8'h01};
        tbl[6]  = '{mk(6, 1'b1, 5'd7, 5'd7, 32'h0, 32'h0, 8'h01, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF), 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 8'h01};
        tbl[7]  = '{mk(7, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 8'h01, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF), 1'b0, 1'b1, 32'h0, 32'h0, 8'h01};
        tbl[8]  = '{mk(8, 1'b0, 5'd1, 5'd2, 32'h9, 32'hA, 8'h05, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0, 32'h9, 32'hA, 8'h00};
        tbl[9]  = '{mk(9, 1'b1, 5'd3, 5'd4, 32'h1, 32'h2, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h1, 32'h2, 8'h01};
        tbl[10] = '{mk(10, 1'b1, 5'd3, 5'd4, 32'hAA, 32'hAB, 8'h01, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0), 1'b1, 1'b1, 32'h1, 32'h2, 8'h01};
        tbl[11] = '{mk(11, 1'b1, 5'd3, 5'd4, 32'hAC, 32'hAD, 8'h01, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0, 32'h0, 32'h0, 8'h00};
        tbl[12] = '{mk(12, 1'b1, 5'd3, 5'd4, 32'hAE, 32'hAF, 8'h01, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0), 1'b1, 1'b0, 32'h0, 32'h0, 8'h00};
        tbl[13] = '{mk(13, 1'b1, 5'd3, 5'd4, 32'hBB, 32'hCC, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'hBB, 32'hCC, 8'h01};
        tbl[14] = '{mk(14, 1'b1, 5'd1, 5'd9, 32'h1, 32'h2, 8'h03, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h1, 32'h2, 8'h03};
        tbl[15] = '{mk(15, 1'b1, 5'd9, 5'd8, 32'h3, 32'h4, 8'h01, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0), 1'b1, 1'b1, 32'h1, 32'h2, 8'h03};
        tbl[16] = '{mk(15, 1'b1, 5'd9, 5'd8, 32'h3, 32'h4, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b1, 1'b0, 32'h0, 32'h0, 8'h00};
        tbl[17] = '{mk(15, 1'b1, 5'd9, 5'd8, 32'h3, 32'h4, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b1, 32'h3, 32'h4, 8'h01};

        // Reset held across clock edges: EX stays empty.
        repeat (2) @(posedge clk);
        #1;
        chk_zero("in_reset");
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 18; k++) begin
            apply(tbl[k].in, st);
            chk($sformatf("tbl%0d_stall", k), {31'd0, st}, {31'd0, tbl[k].stall});
            chk($sformatf("tbl%0d_valid", k), {31'd0, ex_valid}, {31'd0, tbl[k].valid});
            chk($sformatf("tbl%0d_rd1", k), ex_rd1, tbl[k].rd1);
            chk($sformatf("tbl%0d_rd2", k), ex_rd2, tbl[k].rd2);
            chk($sformatf("tbl%0d_ctrl", k), {24'd0, ex_ctrl}, {24'd0, tbl[k].ctrl});
        end
`ifdef ID_EX_PERF_EN
        chk("perf_bubbles_tbl", perf_bubbles, 32'd2);
        chk("perf_flushes_tbl", perf_flushes, 32'd1);
`endif

        // Asynchronous reset between edges while EX holds a valid instruction.
        chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_zero("async_reset");
`ifdef ID_EX_PERF_EN
        chk("perf_bubbles_rst", perf_bubbles, 32'd0);
        chk("perf_flushes_rst", perf_flushes, 32'd0);
`endif
        model = '0;
        m_bubbles = 0;
        m_flushes = 0;
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against the model; small register space provokes hazards.
        for (int n = 0; n < 400; n++) begin
            ri = mk(n, ($urandom_range(3) != 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
                    $urandom, $urandom, 8'($urandom), ($urandom_range(4) == 0),
                    ($urandom_range(7) == 0), 1'($urandom), 5'($urandom_range(7)), $urandom);
            ri.rd = 5'($urandom);
            ri.imm = $urandom;
            apply(ri, st);
        end
`ifdef ID_EX_PERF_EN
        chk("perf_bubbles_rand", perf_bubbles, 32'(m_bubbles));
        chk("perf_flushes_rand", perf_flushes, 32'(m_flushes));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic apply_idle();
        id_valid = 1'b0; id_pc = 32'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_rd1 = 32'd0; id_rd2 = 32'd0; id_imm = 32'd0; id_ctrl = 8'd0;
        wb_regwrite = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0;
        ex_flush = 1'b0; ex_hold = 1'b0;
    endtask

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage MIPS pipeline, sitting directly downstream of the register file. It captures the two read operands (RD1/RD2) with the decoded fields and control word of the instruction in ID, and bypasses a same-cycle writeback into the captured operands. It detects load-use hazards and inserts bubbles, and honours branch flush and downstream hold.

## Interface
Parameters:
- CTRL_W, 8: width of the decoded control word.
- REGWRITE_BIT, 0: index of RegWrite in the control word.
- MEMREAD_BIT, 1: index of MemRead in the control word.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC+4 of the ID instruction.
- id_rs, id_rt, id_rd  in  5 each  register specifiers; id_rs/id_rt drive regfile A1/A2.
- id_rd1, id_rd2  in  32 each  regfile RD1/RD2.
- id_imm  in  32  sign/zero-extended immediate.
- id_ctrl  in  CTRL_W  decoded control word.
- wb_regwrite  in  1  writeback enable (regfile RegWrite).
- wb_a3  in  5  writeback address (regfile A3).
- wb_wd  in  32  writeback data (regfile WD).
- ex_flush  in  1  branch/jump resolved taken in EX; squash ID.
- ex_hold  in  1  downstream multi-cycle unit busy; freeze EX.
- stall  out  1  freeze PC and IF/ID (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  32 each  registered copies.
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers.
- ex_ctrl  out  CTRL_W  registered control word; forced to 0 for bubbles.

## Operation
- Load-use hazard: `lu = ex_valid & ex_ctrl[MEMREAD_BIT] & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)`.
- `stall = (lu | ex_hold) & ~ex_flush`.
- WB bypass, operand 1: if `wb_regwrite & wb_a3 != 0 & wb_a3 == id_rs`, capture wb_wd; otherwise capture id_rd1.
- WB bypass, operand 2: same rule with id_rt, capturing wb_wd or id_rd2.
- The bypass covers the regfile reading the pre-write value in the same cycle it is written.
- Per rising edge, priority order:
  1. ex_flush: load a bubble.
  2. ex_hold: keep all ex_* outputs unchanged.
  3. lu: load a bubble.
  4. Otherwise: load the ID fields, bypassed operands, and `ex_valid = id_valid`.
- Bubble: ex_valid=0, ex_ctrl=0, all other ex_* outputs 0.
- ID with id_valid=0 loads normally; ex_ctrl is forced to 0 whenever ex_valid=0.
- Register 0 never matches as a hazard or bypass source.

## Timing
- Latency: 1 cycle from ID inputs to ex_* outputs.
- stall is combinational from registered EX state plus ex_hold/ex_flush; no internal state machine beyond the pipeline register.
- A load-use hazard costs exactly 1 bubble. On the next cycle ex_ctrl[MEMREAD_BIT]=0, so stall drops.
- Simultaneous ex_flush and ex_hold: flush wins, a bubble is loaded, and stall=0.
- Simultaneous ex_hold and lu: stall=1 and EX is held; once the hold releases, a bubble follows if lu is still true.
- Reset (rst=0, asynchronous): all ex_* outputs 0 and ex_valid=0, so stall=0.
- Reset mid-operation discards the held instruction immediately, without waiting for clk.

## Configuration
- ID_EX_PERF_EN defined: adds outputs `perf_bubbles` (32) and `perf_flushes` (32).
  - `perf_bubbles` increments on each edge that loads a load-use bubble.
  - `perf_flushes` increments on each edge where ex_flush=1.
  - Both wrap modulo 2^32 and reset to 0 with rst.
  - Neither increments while ex_hold holds EX without a flush.
- ID_EX_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, then id_valid=1, id_rd1=0x11, id_rd2=0x22, id_ctrl=0x01 -> one cycle later ex_rd1=0x11, ex_rd2=0x22, ex_valid=1; during reset all ex_*=0 and stall=0.
- EX holds `lw` (ctrl=0x03, ex_rt=5), ID has id_rs=5 -> stall=1 for 1 cycle; the next EX has ex_valid=0, ex_ctrl=0; then the ID instruction enters with stall=0. Repeat with ex_rt=0 -> no stall.
- wb_regwrite=1, wb_a3=7, wb_wd=0xDEADBEEF, id_rs=id_rt=7, id_rd1=id_rd2=0 -> ex_rd1=ex_rd2=0xDEADBEEF. Repeat with wb_a3=0 -> 0.
- ex_hold=1 for 3 cycles with changing ID inputs -> ex_* constant and stall=1; with ex_flush=1 on the 2nd cycle -> bubble loaded and stall=0 that cycle.
- Assert rst=0 between clock edges while ex_valid=1 -> ex_valid and ex_ctrl go to 0 without a clock edge.
- With ID_EX_PERF_EN: 2 load-use bubbles and 3 flushes -> perf_bubbles=2, perf_flushes=3; after reset both read 0.
